// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and FSM state type for the quickdraw CNN layers
package cnn_pkg;

   localparam int FC2_IN_DIM  = 128;
   localparam int NUM_CLASSES = 10;
   localparam int ACT_W       = 32;
   localparam int WGT_W       = 8;
   localparam int CLASS_W     = $clog2(NUM_CLASSES);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      MAC,
      STORE,
      NEXT,
      DONE,
      WAIT_START_LOW
   } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - registered running maximum and its index, strict-greater compare
module argmax_tracker #(
   parameter int VAL_W = 32,
   parameter int IDX_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    valid,
   input  logic signed [VAL_W-1:0] value,
   input  logic        [IDX_W-1:0] idx,
   output logic signed [VAL_W-1:0] max_val,
   output logic        [IDX_W-1:0] max_idx
);

   localparam logic signed [VAL_W-1:0] MOST_NEG = {1'b1, {(VAL_W-1){1'b0}}};

   // Clear seeds the most-negative value so the first candidate always wins;
   // strict compare keeps the earliest (lowest) index on ties.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_val <= '0;
         max_idx <= '0;
      end else if (clear) begin
         max_val <= MOST_NEG;
         max_idx <= '0;
      end else if (valid && (value > max_val)) begin
         max_val <= value;
         max_idx <= idx;
      end
   end

endmodule

// File: rtl/fc2_classifier.sv
// rtl/fc2_classifier.sv - final dense layer with argmax, one MAC per cycle (option: ACC_SATURATE_EN)
module fc2_classifier
   import cnn_pkg::*;
#(
   parameter int IN_DIM = FC2_IN_DIM,
   parameter int ACC_W  = 48
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic signed [ACT_W-1:0]   fc_input [IN_DIM],
   input  logic signed [WGT_W-1:0]   weights  [NUM_CLASSES][IN_DIM],
   input  logic signed [ACT_W-1:0]   biases   [NUM_CLASSES],
   output logic                      busy,
   output logic                      done,
   output logic signed [ACT_W-1:0]   logits   [NUM_CLASSES],
   output logic        [CLASS_W-1:0] class_idx,
   output logic signed [ACT_W-1:0]   max_logit
);

   localparam int IDX_W  = $clog2(IN_DIM);
   localparam int PROD_W = ACT_W + WGT_W;
   localparam logic [IDX_W-1:0]   LAST_IN    = IDX_W'(IN_DIM - 1);
   localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

   state_t                     state;
   state_t                     next_state;
   logic        [CLASS_W-1:0]  class_cnt;
   logic        [IDX_W-1:0]    in_idx;
   logic signed [ACC_W-1:0]    acc;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACT_W-1:0]    narrowed;
   logic                       track_clear;
   logic                       track_valid;

   assign prod = PROD_W'(fc_input[in_idx]) * PROD_W'(weights[class_cnt][in_idx]);

`ifdef ACC_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-ACT_W+1){1'b0}}, {(ACT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-ACT_W+1){1'b1}}, {(ACT_W-1){1'b0}}};

   // Clamp the accumulator into the logit range instead of wrapping.
   always_comb begin
      narrowed = acc[ACT_W-1:0];
      if (acc > SAT_MAX) begin
         narrowed = {1'b0, {(ACT_W-1){1'b1}}};
      end else if (acc < SAT_MIN) begin
         narrowed = {1'b1, {(ACT_W-1){1'b0}}};
      end
   end
`else
   assign narrowed = acc[ACT_W-1:0];
`endif

   assign busy        = (state == INIT) || (state == MAC) || (state == STORE) ||
                        (state == NEXT) || (state == DONE);
   assign track_clear = (state == IDLE) && start;
   assign track_valid = (state == STORE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: one INIT/MAC*IN_DIM/STORE/NEXT pass per class, then a
   // start-low wait so a held start cannot retrigger.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:           if (start) next_state = INIT;
         INIT:           next_state = MAC;
         MAC:            if (in_idx == LAST_IN) next_state = STORE;
         STORE:          next_state = NEXT;
         NEXT:           next_state = (class_cnt == LAST_CLASS) ? DONE : INIT;
         DONE:           next_state = WAIT_START_LOW;
         WAIT_START_LOW: if (!start) next_state = IDLE;
         default:        next_state = IDLE;
      endcase
   end

   // Datapath: counters, accumulator, logit store and done flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done      <= 1'b0;
         class_cnt <= '0;
         in_idx    <= '0;
         acc       <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            logits[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  done      <= 1'b0;
                  class_cnt <= '0;
               end
            end
            INIT: begin
               acc    <= {{(ACC_W-ACT_W){biases[class_cnt][ACT_W-1]}}, biases[class_cnt]};
               in_idx <= '0;
            end
            MAC: begin
               acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
               if (in_idx != LAST_IN) begin
                  in_idx <= in_idx + 1'b1;
               end
            end
            STORE: begin
               logits[class_cnt] <= narrowed;
            end
            NEXT: begin
               if (class_cnt != LAST_CLASS) begin
                  class_cnt <= class_cnt + 1'b1;
               end
            end
            DONE: begin
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   argmax_tracker #(
      .VAL_W (ACT_W),
      .IDX_W (CLASS_W)
   ) u_argmax (
      .clk     (clk),
      .reset   (reset),
      .clear   (track_clear),
      .valid   (track_valid),
      .value   (narrowed),
      .idx     (class_cnt),
      .max_val (max_logit),
      .max_idx (class_idx)
   );

endmodule
